commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO depth in records; power of two, minimum 2.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-004 retire_i  input  1  one instruction retired this cycle; core drives 1 every cycle, since it is single-cycle.
REQ-005 pc_i, instr_i  input  32 each  retired PC and instruction word.
REQ-006 reg_addr_i  input  5  destination register; 0 means no register write.
REQ-007 reg_data_i, mem_addr_i, mem_data_i  input  32 each  writeback data, memory address, store data.
REQ-008 mem_wrt_i  input  1  store performed.
REQ-009 clr_i  input  1  synchronous clear of overflow_o and the drop counter.
REQ-010 out_data_o  output  32  serialized trace word.
REQ-011 out_valid_o  output  1  out_data_o valid.
REQ-012 out_ready_i  input  1  consumer accepts the word when out_valid_o and out_ready_i are both high at a rising edge.
REQ-013 overflow_o  output  1  sticky flag: at least one record was dropped.
REQ-014 drop_cnt_o  output  16  dropped-record count; present only per REQ-030.

Function
REQ-015 A rising edge with retire_i=1 shall capture one record {seq, pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt} into the FIFO.
REQ-016 seq shall be an 8-bit counter incremented on every retire_i=1, including dropped records, wrapping 255->0, so that drops appear as gaps.
REQ-017 Each record shall be emitted as 6 words, in this order: header, pc, instr, reg_data, mem_addr, mem_data.
REQ-018 Header layout: [31:24]=8'hA5, [23:16]=seq, [15]=mem_wrt, [14:13]=0, [12:8]=reg_addr, [7:0]=0.
REQ-019 The serializer FSM shall have two states, IDLE and SEND, with a 3-bit word index 0..5.
REQ-020 In IDLE with the FIFO non-empty, it shall pop one record into an output holding register, go to SEND with index 0, and assert out_valid_o from the next cycle.
REQ-021 Latency: a record captured at edge N into an empty FIFO while the FSM is IDLE shall drive header on out_data_o with out_valid_o=1 after edge N+1.
REQ-022 In SEND, out_data_o and out_valid_o shall stay stable until the word is accepted; acceptance advances the index.
REQ-023 Acceptance at index 5 shall return the FSM to IDLE, deasserting out_valid_o, unless the FIFO is non-empty, in which case it loads the next record directly; back-to-back records have no bubble.
REQ-024 A push while the FIFO is full and no pop occurs in the same cycle shall drop the record, set overflow_o, and increment the drop counter.
REQ-025 A push while full with a pop in the same cycle shall be accepted, with no drop.
REQ-026 Pointers shall use log2(DEPTH)+1 bits; full and empty are derived from the MSB compare, and wrap-around is seamless.
REQ-027 clr_i takes priority over a same-cycle drop: the flag and counter end at 0.

Reset
REQ-028 While rstn_i=0, the following shall be forced asynchronously: FIFO empty, FSM IDLE, index 0, seq 0, out_valid_o 0, out_data_o 0, overflow_o 0, drop_cnt_o 0.
REQ-029 Reset asserted mid-record shall abandon the record; after release, output resumes only with newly captured records, starting at seq 0.

Configuration
REQ-030 Macro TRACE_DROP_CNT_EN shall control the drop counter.
REQ-031 With TRACE_DROP_CNT_EN defined: drop_cnt_o exists as a 16-bit counter saturating at 16'hFFFF.
REQ-032 Without TRACE_DROP_CNT_EN: the port and counter are absent; overflow_o is still implemented.

Structure
REQ-033 Package commit_trace_pkg shall hold: the record struct typedef, the SYNC_BYTE=8'hA5 constant, WORDS_PER_REC=6, and the FSM state enum.
REQ-034 FIFO storage shall be sub-module trace_fifo, parameterized by DEPTH and record type, with push/pop/full/empty ports.

Verification
REQ-035 Single retire, pc=0x100, instr=0x00500093, reg_addr=1, reg_data=5, out_ready_i=1 -> words A5000100, 00000100, 00500093, 00000005, then mem_addr, mem_data; out_valid_o rises after the edge following capture.
REQ-036 Store record, mem_wrt=1, reg_addr=0, mem_addr=0x2000, mem_data=0xDEADBEEF -> header bit15=1 and [12:8]=0; word4=0x2000, word5=0xDEADBEEF.
REQ-037 out_ready_i=0 for 20 cycles with retire_i=1, DEPTH=8 -> 8 records plus 1 in the holding register retained; overflow_o=1; drop_cnt_o=11; later headers show a seq gap of 11.
REQ-038 Full FIFO with out_ready_i=1 at the last word of a record and a same-cycle retire -> no drop, drop_cnt_o unchanged.
REQ-039 More than 256 retires with out_ready_i=1 -> seq wraps FF->00; 6 words per record, with no bubble between records.
REQ-040 rstn_i pulsed low at word index 3 -> out_valid_o=0 immediately; the next header after release has seq=00; clr_i zeroes overflow_o.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// Optional feature macro used by the top level: TRACE_DROP_CNT_EN.
package commit_trace_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         WORDS_PER_REC = 6;

  // One retired-instruction record as captured on a retire edge.
  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
  } trace_rec_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  // Header word: sync byte, sequence number, store flag and destination register.
  function automatic logic [31:0] make_header(input trace_rec_t rec);
    return {SYNC_BYTE, rec.seq, rec.mem_wrt, 2'b00, rec.reg_addr, 8'h00};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with extra-MSB pointers; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = logic [31:0]
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push_i,
  input  rec_t data_i,
  input  logic pop_i,
  output rec_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  rec_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; the head entry is read combinationally before this edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction and
// serializes each record as six 32-bit words over a valid/ready port.
// Define TRACE_DROP_CNT_EN to add the saturating 16-bit drop counter port.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        retire_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_wrt_i,
  input  logic        clr_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
`ifdef TRACE_DROP_CNT_EN
  output logic [15:0] drop_cnt_o,
`endif
  output logic        overflow_o
);

  localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_REC - 1);

  ser_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  trace_rec_t hold_q, hold_d;
  logic [7:0] seq_q;
  logic       overflow_q;
  trace_rec_t push_rec, fifo_rdata;
  logic       fifo_pop, fifo_full, fifo_empty, drop;
  logic [31:0] word;

  assign push_rec = '{seq: seq_q, pc: pc_i, instr: instr_i, reg_addr: reg_addr_i,
                      reg_data: reg_data_i, mem_addr: mem_addr_i,
                      mem_data: mem_data_i, mem_wrt: mem_wrt_i};

  assign drop = retire_i && fifo_full && !fifo_pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (retire_i),
    .data_i  (push_rec),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Serializer state, word index and holding register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: load from FIFO when idle, or chain straight into the next record after the last word.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          state_d  = SEND;
          idx_d    = '0;
        end
      end
      SEND: begin
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              hold_d   = fifo_rdata;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Word select from the holding register; output is zero whenever nothing is offered.
  always_comb begin
    word = '0;
    case (idx_q)
      3'd0:    word = make_header(hold_q);
      3'd1:    word = hold_q.pc;
      3'd2:    word = hold_q.instr;
      3'd3:    word = hold_q.reg_data;
      3'd4:    word = hold_q.mem_addr;
      3'd5:    word = hold_q.mem_data;
      default: word = '0;
    endcase
  end

  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = out_valid_o ? word : 32'h0;

  // Sequence counter advances on every retire, dropped or not, so gaps reveal drops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       seq_q <= '0;
    else if (retire_i) seq_q <= seq_q + 8'd1;
  end

  // Sticky overflow flag; a clear wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    overflow_q <= 1'b0;
    else if (clr_i) overflow_q <= 1'b0;
    else if (drop)  overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating drop counter; a clear wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                           drop_cnt_q <= '0;
    else if (clr_i)                        drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH = 8).
// Drop counter checks are included when TRACE_DROP_CNT_EN is defined.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        retire;
  logic [31:0] pc, instr, regData, memAddr, memData;
  logic [4:0]  regAddr;
  logic        memWrt;
  logic        clr;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        overflow;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0] dropCnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  commit_trace_buffer #(.DEPTH(8)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .retire_i    (retire),
    .pc_i        (pc),
    .instr_i     (instr),
    .reg_addr_i  (regAddr),
    .reg_data_i  (regData),
    .mem_addr_i  (memAddr),
    .mem_data_i  (memData),
    .mem_wrt_i   (memWrt),
    .clr_i       (clr),
    .out_data_o  (outData),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
`ifdef TRACE_DROP_CNT_EN
    .drop_cnt_o  (dropCnt),
`endif
    .overflow_o  (overflow)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input logic [7:0] s, input logic w, input logic [4:0] ra);
    return {8'hA5, s, w, 2'b00, ra, 8'h00};
  endfunction

  // Present record fields for the next retire.
  task automatic setRecord(input logic [31:0] p, input logic [31:0] i, input logic [4:0] ra,
                           input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md,
                           input logic w);
    pc = p; instr = i; regAddr = ra; regData = rd; memAddr = ma; memData = md; memWrt = w;
  endtask

  // Drive control inputs, then advance one rising edge and settle.
  task automatic applyStimulus(input logic ret, input logic rdy, input logic cl);
    retire = ret; outReady = rdy; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expData);
    checkValue({tag, "_valid"}, {31'b0, outValid}, {31'b0, expValid});
    checkValue({tag, "_data"}, outData, expData);
  endtask

  initial begin
    rstn = 1'b0; retire = 1'b0; outReady = 1'b1; clr = 1'b0;
    setRecord(0, 0, 0, 0, 0, 0, 1'b0);
    #3;
    checkOutput("reset", 1'b0, 32'h0);
    checkValue("reset_ovf", {31'b0, overflow}, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    checkValue("reset_drop", {16'b0, dropCnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single record, seq 0: latency and all six words.
    setRecord(32'h100, 32'h00500093, 5'd1, 32'd5, 32'h44, 32'h55, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lat_capture", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("single_w0", 1'b1, 32'hA5000100);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_w1", 1'b1, 32'h00000100);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_w2", 1'b1, 32'h00500093);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_w3", 1'b1, 32'h00000005);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_w4", 1'b1, 32'h00000044);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_w5", 1'b1, 32'h00000055);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("single_idle", 1'b0, 32'h0);

    // Store record, seq 1.
    setRecord(32'h104, 32'h00112023, 5'd0, 32'h0, 32'h2000, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w0", 1'b1, 32'hA5018000);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w1", 1'b1, 32'h00000104);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w2", 1'b1, 32'h00112023);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w3", 1'b1, 32'h00000000);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w4", 1'b1, 32'h00002000);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_w5", 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("store_idle", 1'b0, 32'h0);

    // Two consecutive retires, seq 2 and 3: second record follows with no bubble.
    setRecord(32'h200, 32'h11, 5'd2, 32'h22, 32'h33, 32'h44, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    setRecord(32'h300, 32'h99, 5'd4, 32'h66, 32'h77, 32'h88, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("b2b_a_w0", 1'b1, 32'hA5020200);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_a_w1", 1'b1, 32'h200);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_a_w2", 1'b1, 32'h11);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_a_w3", 1'b1, 32'h22);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_a_w4", 1'b1, 32'h33);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_a_w5", 1'b1, 32'h44);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w0", 1'b1, 32'hA5030400);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w1", 1'b1, 32'h300);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w2", 1'b1, 32'h99);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w3", 1'b1, 32'h66);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w4", 1'b1, 32'h77);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_b_w5", 1'b1, 32'h88);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("b2b_idle", 1'b0, 32'h0);

    // Stalled consumer for 20 retires, seq 4..23: 1 held + 8 queued, 11 dropped.
    for (int i = 0; i < 20; i++) begin
      setRecord(32'h1000 + 32'(i * 4), 32'(i), 5'd3, 32'h0, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkValue("ovf_flag", {31'b0, overflow}, 32'd1);
`ifdef TRACE_DROP_CNT_EN
    checkValue("ovf_drop", {16'b0, dropCnt}, 32'd11);
`endif
    checkOutput("ovf_stall_hdr", 1'b1, 32'hA5040300);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_stable_hdr", 1'b1, 32'hA5040300);
    for (int r = 0; r < 9; r++) begin
      checkOutput("ovf_hdr", 1'b1, hdr(8'(4 + r), 1'b0, 5'd3));
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("ovf_pc", 1'b1, 32'h1000 + 32'(r * 4));
      repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("ovf_drained", 1'b0, 32'h0);

    // Next record after the drops shows seq 24 (gap after 12).
    setRecord(32'h2000, 32'h0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("gap_hdr", 1'b1, 32'hA5180300);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("gap_idle", 1'b0, 32'h0);
    checkValue("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Clear.
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkValue("clr_flag", {31'b0, overflow}, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    checkValue("clr_drop", {16'b0, dropCnt}, 32'd0);
`endif

    // Fill (seq 25..33), then a drop (seq 34) coinciding with clear.
    for (int i = 0; i < 9; i++) begin
      setRecord(32'h3000 + 32'(i * 4), 32'h0, 5'd5, 32'h0, 32'h0, 32'hF00 + 32'(i), 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkValue("clr_prio_flag", {31'b0, overflow}, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    checkValue("clr_prio_drop", {16'b0, dropCnt}, 32'd0);
`endif
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("full_w5", 1'b1, 32'h00000F00);
    // Retire (seq 35) while full, at the same edge the last word is accepted.
    setRecord(32'h4000, 32'h0, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkValue("full_pop_flag", {31'b0, overflow}, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    checkValue("full_pop_drop", {16'b0, dropCnt}, 32'd0);
`endif
    for (int r = 0; r < 9; r++) begin
      checkOutput("full_hdr", 1'b1, hdr((r < 8) ? 8'(26 + r) : 8'd35, 1'b0, 5'd5));
      repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("full_drained", 1'b0, 32'h0);

    // 230 records, seq 36..265 (wraps), one retire every 6 cycles: continuous valid.
    setRecord(32'h5000, 32'h0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int c = 0; c <= 6 * 230; c++) begin
      applyStimulus((c % 6 == 0) && (c < 6 * 230), 1'b1, 1'b0);
      if (c >= 1) checkValue("wrap_valid", {31'b0, outValid}, 32'd1);
      if (c % 6 == 1) checkValue("wrap_hdr", outData, hdr(8'(36 + (c - 1) / 6), 1'b0, 5'd7));
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("wrap_idle", 1'b0, 32'h0);

    // Reset at word index 3 of record seq 0x0A.
    setRecord(32'h6000, 32'h0, 5'd1, 32'hCAFE, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("mid_w0", 1'b1, 32'hA50A0100);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mid_w3", 1'b1, 32'h0000CAFE);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst", 1'b0, 32'h0);
    checkValue("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    #1;
    rstn = 1'b1;
    setRecord(32'h7000, 32'h0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("post_rst_hdr", 1'b1, 32'hA5000100);
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("post_rst_pc", 1'b1, 32'h7000);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_idle", 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
